// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and geometry for the direct-mapped instruction cache
package icache_pkg;

    typedef enum logic [1:0] {
        ST_LOOKUP = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 4;
    localparam int WORD_W         = 32;

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    function automatic logic [WORD_W-1:0] line_word(input line_t line, input logic [1:0] sel);
        return line[sel];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - data/tag arrays and valid vector with one read and one line-write port
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic             o_rd_valid,
    output line_t            o_rd_line,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  line_t            i_wr_line
);

    line_t            r_data [LINES];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;

    // Only the valid vector needs clearing; stale data/tags are harmless once invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[i_wr_idx] <= i_wr_line;
            r_tag[i_wr_idx]  <= i_wr_tag;
        end
    end

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - instruction cache controller: lookup, miss request and 4-beat line refill
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int LINES  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_re,
    output logic [31:0]       icache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-5:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_t            r_state;
    logic [ADDR_W-1:2] r_miss_addr;
    logic [1:0]        r_beat;
    logic [2:0][31:0]  r_line_buf;
    logic [31:0]       r_dout;
    logic              r_stall;
    logic              r_req_valid;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_word;
    logic [IDX_W-1:0]  w_miss_idx;
    logic [TAG_W-1:0]  w_miss_tag;
    logic [1:0]        w_miss_word;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_valid;
    line_t             w_rd_line;
    logic              w_hit;
    logic              w_last_beat;
    line_t             w_fill_line;
    logic [31:0]       w_fill_word;
    logic              w_unused;

    assign w_idx       = icache_addr[OFFSET_W+IDX_W-1:OFFSET_W];
    assign w_tag       = icache_addr[ADDR_W-1:OFFSET_W+IDX_W];
    assign w_word      = icache_addr[3:2];
    assign w_miss_idx  = r_miss_addr[OFFSET_W+IDX_W-1:OFFSET_W];
    assign w_miss_tag  = r_miss_addr[ADDR_W-1:OFFSET_W+IDX_W];
    assign w_miss_word = r_miss_addr[3:2];
    assign w_unused    = ^icache_addr[1:0];

    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
    assign w_last_beat = (r_state == ST_FILL) && mem_resp_valid && (r_beat == 2'd3);

    // The final beat bypasses the buffer so the line is written on the edge that accepts it.
    assign w_fill_line = {mem_resp_data, r_line_buf[2], r_line_buf[1], r_line_buf[0]};
    assign w_fill_word = line_word(w_fill_line, w_miss_word);

    icache_line_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_idx),
        .o_rd_tag   (w_rd_tag),
        .o_rd_valid (w_rd_valid),
        .o_rd_line  (w_rd_line),
        .i_we       (w_last_beat),
        .i_wr_idx   (w_miss_idx),
        .i_wr_tag   (w_miss_tag),
        .i_wr_line  (w_fill_line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LOOKUP;
            r_miss_addr <= '0;
            r_beat      <= 2'd0;
            r_line_buf  <= '0;
            r_dout      <= '0;
            r_stall     <= 1'b0;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOOKUP: begin
                    if (icache_re) begin
                        if (w_hit) begin
                            r_dout <= line_word(w_rd_line, w_word);
                        end else begin
                            r_miss_addr <= icache_addr[ADDR_W-1:2];
                            r_stall     <= 1'b1;
                            r_req_valid <= 1'b1;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_beat      <= 2'd0;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_resp_valid) begin
                        r_beat <= r_beat + 2'd1;
                        case (r_beat)
                            2'd0:    r_line_buf[0] <= mem_resp_data;
                            2'd1:    r_line_buf[1] <= mem_resp_data;
                            2'd2:    r_line_buf[2] <= mem_resp_data;
                            default: begin
                                r_dout  <= w_fill_word;
                                r_stall <= 1'b0;
                                r_state <= ST_LOOKUP;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state     <= ST_LOOKUP;
                    r_stall     <= 1'b0;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign icache_dout   = r_dout;
    assign stall         = r_stall;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_miss_addr[ADDR_W-1:OFFSET_W];

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl with vector table and reference model
module tb_icache_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [27:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: which line address (byte address >> 4) each of the 64 slots holds, -1 if none.
    longint model_line [64];

    icache_ctrl #(.LINES(64), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [27:0] line, input logic [1:0] w);
        if (line == 28'h4)  return 32'hA0 + {30'd0, w};
        if (line == 28'h44) return 32'hB0 + {30'd0, w};
        return {line, 2'b00, w} ^ 32'h5A5A_0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        return model_line[addr[9:4]] == longint'(addr[31:4]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_line[i] = -1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Called right after a negedge; returns right after a negedge with icache_re low.
    task automatic fetch(input logic [31:0] addr, input int rdy_dly, input int gap,
                         input bit exp_hit, input logic [31:0] exp_dout, input string name);
        logic [27:0] line;
        line        = addr[31:4];
        icache_addr = addr;
        icache_re   = 1'b1;
        @(negedge clk);
        if (exp_hit) begin
            check({name, "_hit_stall"}, {31'd0, stall}, 32'd0);
            check({name, "_hit_reqv"}, {31'd0, mem_req_valid}, 32'd0);
            check({name, "_hit_dout"}, icache_dout, exp_dout);
        end else begin
            check({name, "_miss_stall"}, {31'd0, stall}, 32'd1);
            check({name, "_miss_reqv"}, {31'd0, mem_req_valid}, 32'd1);
            check({name, "_miss_addr"}, {4'd0, mem_req_addr}, {4'd0, line});
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                check({name, "_wait_reqv"}, {31'd0, mem_req_valid}, 32'd1);
                check({name, "_wait_addr"}, {4'd0, mem_req_addr}, {4'd0, line});
                check({name, "_wait_stall"}, {31'd0, stall}, 32'd1);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check({name, "_accepted_reqv"}, {31'd0, mem_req_valid}, 32'd0);
            for (int b = 0; b < 4; b++) begin
                for (int g = 0; g < gap; g++) begin
                    mem_resp_data = $urandom;
                    @(negedge clk);
                    check({name, "_gap_stall"}, {31'd0, stall}, 32'd1);
                end
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(line, 2'(b));
                @(negedge clk);
                mem_resp_valid = 1'b0;
                if (b < 3) check({name, "_beat_stall"}, {31'd0, stall}, 32'd1);
            end
            check({name, "_fill_stall"}, {31'd0, stall}, 32'd0);
            check({name, "_fill_dout"}, icache_dout, exp_dout);
            model_line[addr[9:4]] = longint'(line);
        end
        icache_re = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] held;
        logic [31:0] a;
        vecs[0] = '{32'h0000_0040, 1'b0, 32'h0000_00A0};
        vecs[1] = '{32'h0000_004C, 1'b1, 32'h0000_00A3};
        vecs[2] = '{32'h0000_0440, 1'b0, 32'h0000_00B0};
        vecs[3] = '{32'h0000_0040, 1'b0, 32'h0000_00A0};
        vecs[4] = '{32'h0000_0045, 1'b1, 32'h0000_00A1};
        vecs[5] = '{32'h0000_0448, 1'b0, 32'h0000_00B2};

        reset          = 1'b1;
        icache_addr    = '0;
        icache_re      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_reqv", {31'd0, mem_req_valid}, 32'd0);
        check("reset_dout", icache_dout, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            fetch(vecs[i].addr, 0, 0, vecs[i].exp_hit, vecs[i].exp_dout, "vec");

        // Slow memory: request held for 7 cycles, beats spaced by 2 idle cycles.
        fetch(32'h0000_3A0C, 7, 2, 1'b0, mem_word(28'h3A0, 2'd3), "slow");
        fetch(32'h0000_3A04, 0, 0, 1'b1, mem_word(28'h3A0, 2'd1), "slow_rehit");

        // Reset arriving mid-fill after two beats.
        icache_addr = 32'h0000_2004;
        icache_re   = 1'b1;
        @(negedge clk);
        check("rstfill_stall", {31'd0, stall}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(28'h200, 2'(b));
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        check("rstfill_prestall", {31'd0, stall}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstfill_async_stall", {31'd0, stall}, 32'd0);
        check("rstfill_async_reqv", {31'd0, mem_req_valid}, 32'd0);
        check("rstfill_async_dout", icache_dout, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        icache_re = 1'b0;
        model_clear();
        for (int b = 2; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(28'h200, 2'(b));
            @(negedge clk);
            check("stray_stall", {31'd0, stall}, 32'd0);
            check("stray_reqv", {31'd0, mem_req_valid}, 32'd0);
            check("stray_dout", icache_dout, 32'd0);
        end
        mem_resp_valid = 1'b0;
        fetch(32'h0000_2004, 0, 0, 1'b0, mem_word(28'h200, 2'd1), "refetch_after_reset");
        fetch(32'h0000_0040, 0, 0, 1'b0, 32'h0000_00A0, "vec0_after_reset");

        // Idle lookups with spurious response beats must leave everything alone.
        fetch(32'h0000_2008, 0, 0, 1'b1, mem_word(28'h200, 2'd2), "hold_hit");
        held = mem_word(28'h200, 2'd2);
        icache_addr = 32'h0000_7770;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = (i != 1);
            mem_resp_data  = $urandom;
            @(negedge clk);
            check("hold_dout", icache_dout, held);
            check("hold_stall", {31'd0, stall}, 32'd0);
            check("hold_reqv", {31'd0, mem_req_valid}, 32'd0);
        end
        mem_resp_valid = 1'b0;
        fetch(32'h0000_200C, 0, 0, 1'b1, mem_word(28'h200, 2'd3), "hold_rehit");

        // Randomized fetches against the slot model; small tag range forces conflicts and hits.
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 63) << 4) | $urandom_range(0, 15);
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 2), model_hit(a),
                  mem_word(a[31:4], a[3:2]), "rand");
            if ($urandom_range(0, 3) == 0) begin
                mem_resp_valid = $urandom_range(0, 1);
                mem_req_ready  = $urandom_range(0, 1);
                @(negedge clk);
                mem_resp_valid = 1'b0;
                mem_req_ready  = 1'b0;
                check("rand_idle_stall", {31'd0, stall}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
